// File: rtl/window_disc_pkg.sv
// Shared definitions for the multi-window amplitude/time discriminator.
//   - FSM state encodings (2-bit, also the value driven on fsm_state)
//   - default widths for the data path and the sample-offset counter
//   - field_lsb(): bit offset of field idx in a flattened {..., f1, f0} bus
package window_disc_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int NUM_WIN_DEF = 4;
  localparam int CNT_W_DEF   = 10;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_REFRACT = 2'd2;

  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/window_discriminator_multi_win_check.sv
// win_check: one amplitude/time window, purely combinational.
//   en        in   window enable
//   offset    in   sample offset since the arming crossing
//   start     in   first offset covered, inclusive
//   stop      in   last offset covered, inclusive
//   sample    in   signed amplitude
//   lo / hi   in   signed amplitude bounds, inclusive
//   in_range  out  enabled and offset inside [start, stop]
//   hit       out  in_range and amplitude inside [lo, hi]
// A window with start > stop never reports in_range, so it can never hit.
module win_check #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic                     en,
  input  logic [CNT_W-1:0]         offset,
  input  logic [CNT_W-1:0]         start,
  input  logic [CNT_W-1:0]         stop,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] lo,
  input  logic signed [DATA_W-1:0] hi,
  output logic                     in_range,
  output logic                     hit
);

  assign in_range = en && (offset >= start) && (offset <= stop);
  assign hit      = in_range && (sample >= lo) && (sample <= hi);

endmodule

// File: rtl/window_discriminator_multi.sv
// window_discriminator_multi: threshold-armed multi-window event discriminator.
// Follows a stream of signed samples, arms on a threshold crossing and then
// either accepts at once (threshold-only mode) or checks NUM_WIN amplitude/time
// windows up to offset stop_max before pulsing detect or reject.
//   dataclk       in   clock, rising edge
//   reset         in   synchronous, active-low
//   sample_valid  in   sample strobe; all state advances only on it
//   sample        in   signed amplitude
//   thrsh         in   signed arming threshold
//   thrsh_pol     in   1: upward crossing, 0: downward crossing
//   fsm_mode      in   0: threshold-only, 1: window mode
//   win_en/start/stop/lo/hi  in  flattened per-window configuration
//   stop_max      in   offset at which the decision is taken
//   refract       in   valid samples ignored after a decision
//   detect        out  one-cycle accept pulse
//   reject        out  one-cycle reject pulse
//   in_window     out  an enabled window covers the current offset (ARMED only)
//   hit_mask      out  sticky per-window hits of the current/last event
//   fsm_state     out  state encoding
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a threshold crossing against the previous sample
// S_ARMED   | collecting window hits, cnt = offset of the next valid sample
// S_REFRACT | ignoring samples, cnt = samples still to be ignored
module window_discriminator_multi
  import window_disc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_WIN = NUM_WIN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                        dataclk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic signed [DATA_W-1:0]    sample,
  input  logic signed [DATA_W-1:0]    thrsh,
  input  logic                        thrsh_pol,
  input  logic                        fsm_mode,
  input  logic [NUM_WIN-1:0]          win_en,
  input  logic [NUM_WIN*CNT_W-1:0]    win_start,
  input  logic [NUM_WIN*CNT_W-1:0]    win_stop,
  input  logic [NUM_WIN*DATA_W-1:0]   win_lo,
  input  logic [NUM_WIN*DATA_W-1:0]   win_hi,
  input  logic [CNT_W-1:0]            stop_max,
  input  logic [CNT_W-1:0]            refract,
  output logic                        detect,
  output logic                        reject,
  output logic                        in_window,
  output logic [NUM_WIN-1:0]          hit_mask,
  output logic [1:0]                  fsm_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]                 state;
  logic [CNT_W-1:0]           cnt;
  logic signed [DATA_W-1:0]   prev;
  logic                       prev_vld;

  logic [NUM_WIN-1:0]         en_l;
  logic [NUM_WIN*CNT_W-1:0]   start_l;
  logic [NUM_WIN*CNT_W-1:0]   stop_l;
  logic [NUM_WIN*DATA_W-1:0]  lo_l;
  logic [NUM_WIN*DATA_W-1:0]  hi_l;
  logic [CNT_W-1:0]           stop_max_l;
  logic [CNT_W-1:0]           refract_l;

  // The crossing sample is offset 0 and is evaluated in the same cycle the
  // config is latched, so in IDLE the windows see the live config instead of
  // the (not yet updated) latched copy.
  logic                       idle;
  logic [NUM_WIN-1:0]         en_sel;
  logic [NUM_WIN*CNT_W-1:0]   start_sel;
  logic [NUM_WIN*CNT_W-1:0]   stop_sel;
  logic [NUM_WIN*DATA_W-1:0]  lo_sel;
  logic [NUM_WIN*DATA_W-1:0]  hi_sel;
  logic [CNT_W-1:0]           stop_max_sel;
  logic [CNT_W-1:0]           refract_sel;
  logic [CNT_W-1:0]           offset;

  logic [NUM_WIN-1:0]         in_range_vec;
  logic [NUM_WIN-1:0]         hit_vec;
  logic [NUM_WIN-1:0]         hit_mask_next;
  logic                       crossing;
  logic                       at_stop;
  logic                       accept;

  assign idle         = (state == S_IDLE);
  assign en_sel       = idle ? win_en    : en_l;
  assign start_sel    = idle ? win_start : start_l;
  assign stop_sel     = idle ? win_stop  : stop_l;
  assign lo_sel       = idle ? win_lo    : lo_l;
  assign hi_sel       = idle ? win_hi    : hi_l;
  assign stop_max_sel = idle ? stop_max  : stop_max_l;
  assign refract_sel  = idle ? refract   : refract_l;
  assign offset       = idle ? '0        : cnt;

  assign crossing = prev_vld &&
                    (thrsh_pol ? ((prev < thrsh) && (sample >= thrsh))
                               : ((prev > thrsh) && (sample <= thrsh)));

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    localparam int unsigned C_LSB = field_lsb(k, CNT_W);
    localparam int unsigned D_LSB = field_lsb(k, DATA_W);

    win_check #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_win (
      .en       (en_sel[k]),
      .offset   (offset),
      .start    (start_sel[C_LSB +: CNT_W]),
      .stop     (stop_sel[C_LSB +: CNT_W]),
      .sample   (sample),
      .lo       (lo_sel[D_LSB +: DATA_W]),
      .hi       (hi_sel[D_LSB +: DATA_W]),
      .in_range (in_range_vec[k]),
      .hit      (hit_vec[k])
    );
  end

  // A new arming starts from an empty mask; while ARMED hits accumulate.
  assign hit_mask_next = idle ? hit_vec : (hit_mask | hit_vec);
  assign at_stop       = (offset == stop_max_sel);
  assign accept        = ((hit_mask_next & en_sel) == en_sel);

  assign in_window = (state == S_ARMED) && (|in_range_vec);
  assign fsm_state = state;

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      detect     <= 1'b0;
      reject     <= 1'b0;
      hit_mask   <= '0;
      en_l       <= '0;
      start_l    <= '0;
      stop_l     <= '0;
      lo_l       <= '0;
      hi_l       <= '0;
      stop_max_l <= '0;
      refract_l  <= '0;
    end else begin
      detect <= 1'b0;
      reject <= 1'b0;
      if (sample_valid) begin
        prev     <= sample;
        prev_vld <= 1'b1;
        case (state)
          S_IDLE: begin
            if (crossing) begin
              en_l       <= win_en;
              start_l    <= win_start;
              stop_l     <= win_stop;
              lo_l       <= win_lo;
              hi_l       <= win_hi;
              stop_max_l <= stop_max;
              refract_l  <= refract;
              if (!fsm_mode) begin
                hit_mask <= '0;
                detect   <= 1'b1;
                state    <= S_REFRACT;
                cnt      <= refract_sel;
              end else begin
                hit_mask <= hit_mask_next;
                if (at_stop) begin
                  detect <= accept;
                  reject <= !accept;
                  state  <= S_REFRACT;
                  cnt    <= refract_sel;
                end else begin
                  state <= S_ARMED;
                  cnt   <= CNT_ONE;
                end
              end
            end
          end
          S_ARMED: begin
            hit_mask <= hit_mask_next;
            if (at_stop) begin
              detect <= accept;
              reject <= !accept;
              state  <= S_REFRACT;
              cnt    <= refract_sel;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_REFRACT: begin
            // cnt holds samples still to ignore; refract of 0 or 1 both
            // consume exactly one sample.
            if (cnt <= CNT_ONE) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_discriminator_multi.sv
module tb_window_discriminator_multi;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int CW = 10;

  logic                 dataclk = 1'b0;
  logic                 reset = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] sample = '0;
  logic signed [DW-1:0] thrsh = '0;
  logic                 thrsh_pol = 1'b0;
  logic                 fsm_mode = 1'b0;
  logic [NW-1:0]        win_en = '0;
  logic [NW*CW-1:0]     win_start = '0;
  logic [NW*CW-1:0]     win_stop = '0;
  logic [NW*DW-1:0]     win_lo = '0;
  logic [NW*DW-1:0]     win_hi = '0;
  logic [CW-1:0]        stop_max = '0;
  logic [CW-1:0]        refract = '0;
  logic                 detect;
  logic                 reject;
  logic                 in_window;
  logic [NW-1:0]        hit_mask;
  logic [1:0]           fsm_state;

  int compared = 0;
  int mismatched = 0;
  logic det_q, rej_q, inw_q;

  window_discriminator_multi #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW)) dut (
    .dataclk(dataclk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .thrsh(thrsh), .thrsh_pol(thrsh_pol), .fsm_mode(fsm_mode), .win_en(win_en),
    .win_start(win_start), .win_stop(win_stop), .win_lo(win_lo), .win_hi(win_hi),
    .stop_max(stop_max), .refract(refract), .detect(detect), .reject(reject),
    .in_window(in_window), .hit_mask(hit_mask), .fsm_state(fsm_state)
  );

  always #5 dataclk = ~dataclk;

  task automatic set_win(input int k, input int st, input int sp, input int lo, input int hi);
    win_start[k*CW +: CW] = CW'(st);
    win_stop[k*CW +: CW]  = CW'(sp);
    win_lo[k*DW +: DW]    = DW'(lo);
    win_hi[k*DW +: DW]    = DW'(hi);
  endtask

  // One valid sample, then the registered outputs it produced, then idle gap cycles.
  task automatic send(input int v, input int gap);
    @(negedge dataclk);
    sample_valid = 1'b1;
    sample = DW'(v);
    @(negedge dataclk);
    sample_valid = 1'b0;
    det_q = detect;
    rej_q = reject;
    inw_q = in_window;
    repeat (gap) @(negedge dataclk);
  endtask

  task automatic cfg_case1();
    win_en = '0; win_start = '0; win_stop = '0; win_lo = '0; win_hi = '0;
    thrsh = 16'sd100; thrsh_pol = 1'b1; fsm_mode = 1'b1;
    win_en = 4'b0001;
    set_win(0, 2, 4, 200, 400);
    stop_max = 10'd6; refract = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge dataclk);
    compared++;
    if ({detect, reject, in_window, fsm_state, hit_mask} !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 000000000", {detect, reject, in_window, fsm_state, hit_mask});
    end
    reset = 1'b1;
    @(negedge dataclk);
  endtask

  task automatic test_window_detect();
    logic early;
    cfg_case1();
    send(0, 0);
    compared++;
    if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL first_sample_no_arm: state %0d want 0", fsm_state); end
    send(150, 0);
    compared++;
    if (fsm_state !== 2'd1) begin mismatched++; $display("FAIL arm_on_cross: state %0d want 1", fsm_state); end
    compared++;
    if (inw_q !== 1'b0) begin mismatched++; $display("FAIL in_window_off1: got %b want 0", inw_q); end
    send(0, 0);
    compared++;
    if (inw_q !== 1'b1) begin mismatched++; $display("FAIL in_window_off2: got %b want 1", inw_q); end
    early = 1'b0;
    send(300, 0); early |= det_q | rej_q;
    send(0, 0);   early |= det_q | rej_q;
    send(0, 0);   early |= det_q | rej_q;
    send(0, 0);   early |= det_q | rej_q;
    compared++;
    if (early !== 1'b0) begin mismatched++; $display("FAIL case1_early_pulse: got %b want 0", early); end
    send(0, 0);
    compared++;
    if ({det_q, rej_q} !== 2'b10) begin mismatched++; $display("FAIL case1_decision: det/rej %b want 10", {det_q, rej_q}); end
    compared++;
    if (hit_mask !== 4'b0001) begin mismatched++; $display("FAIL case1_hit_mask: got %b want 0001", hit_mask); end
    compared++;
    if (fsm_state !== 2'd2) begin mismatched++; $display("FAIL case1_refract: state %0d want 2", fsm_state); end
    @(negedge dataclk);
    compared++;
    if (detect !== 1'b0) begin mismatched++; $display("FAIL detect_one_cycle: got %b want 0", detect); end
    send(0, 0);
    compared++;
    if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL refract0_idle: state %0d want 0", fsm_state); end
  endtask

  task automatic test_window_reject();
    cfg_case1();
    send(150, 0);
    send(0, 0);
    send(500, 0);
    send(0, 0); send(0, 0); send(0, 0);
    send(0, 0);
    compared++;
    if ({det_q, rej_q} !== 2'b01) begin mismatched++; $display("FAIL case2_decision: det/rej %b want 01", {det_q, rej_q}); end
    compared++;
    if (hit_mask !== 4'b0000) begin mismatched++; $display("FAIL case2_hit_mask: got %b want 0000", hit_mask); end
    send(0, 0);
  endtask

  task automatic test_threshold_refract();
    thrsh = -16'sd50; thrsh_pol = 1'b0; fsm_mode = 1'b0; refract = 10'd3;
    send(0, 0);
    compared++;
    if (det_q !== 1'b0) begin mismatched++; $display("FAIL case3_no_cross: det %b want 0", det_q); end
    send(-60, 0);
    compared++;
    if (det_q !== 1'b1) begin mismatched++; $display("FAIL case3_detect: det %b want 1", det_q); end
    send(0, 0);
    send(-60, 0);
    compared++;
    if (det_q !== 1'b0) begin mismatched++; $display("FAIL case3_refract_ignore: det %b want 0", det_q); end
    compared++;
    if (fsm_state !== 2'd2) begin mismatched++; $display("FAIL case3_still_refract: state %0d want 2", fsm_state); end
    send(0, 0);
    compared++;
    if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL case3_back_idle: state %0d want 0", fsm_state); end
    send(-60, 0);
    compared++;
    if (det_q !== 1'b1) begin mismatched++; $display("FAIL case3_second_detect: det %b want 1", det_q); end
    send(0, 0); send(0, 0); send(0, 0);
    compared++;
    if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL case3_idle_again: state %0d want 0", fsm_state); end
  endtask

  task automatic test_partial_hits();
    cfg_case1();
    win_en = 4'b0011;
    set_win(1, 1, 3, -100, 50);
    stop_max = 10'd5;
    send(150, 0);
    compared++;
    if (inw_q !== 1'b1) begin mismatched++; $display("FAIL case4_in_window_off1: got %b want 1", inw_q); end
    send(0, 0); send(0, 0); send(0, 0); send(0, 0);
    send(0, 0);
    compared++;
    if ({det_q, rej_q} !== 2'b01) begin mismatched++; $display("FAIL case4_decision: det/rej %b want 01", {det_q, rej_q}); end
    compared++;
    if (hit_mask !== 4'b0010) begin mismatched++; $display("FAIL case4_hit_mask: got %b want 0010", hit_mask); end
    send(0, 0);
  endtask

  task automatic test_reset_abort();
    logic pulse;
    cfg_case1();
    send(150, 0); send(0, 0); send(300, 0);
    compared++;
    if ({fsm_state, hit_mask} !== 6'b010001) begin
      mismatched++; $display("FAIL case5_pre_abort: got %b want 010001", {fsm_state, hit_mask});
    end
    @(negedge dataclk);
    reset = 1'b0;
    pulse = 1'b0;
    @(negedge dataclk);
    compared++;
    if ({detect, reject, in_window, fsm_state, hit_mask} !== 9'b0) begin
      mismatched++; $display("FAIL case5_abort_clear: got %b want 000000000", {detect, reject, in_window, fsm_state, hit_mask});
    end
    @(negedge dataclk); pulse |= detect | reject;
    reset = 1'b1;
    @(negedge dataclk); pulse |= detect | reject;
    compared++;
    if (pulse !== 1'b0) begin mismatched++; $display("FAIL case5_no_pulse: got %b want 0", pulse); end
    send(150, 0);
    compared++;
    if (fsm_state !== 2'd0) begin mismatched++; $display("FAIL case5_first_no_arm: state %0d want 0", fsm_state); end
    send(0, 0);
    send(150, 0);
    compared++;
    if (fsm_state !== 2'd1) begin mismatched++; $display("FAIL case5_rearm: state %0d want 1", fsm_state); end
    send(0, 0); send(0, 0); send(0, 0); send(0, 0); send(0, 0);
    send(0, 0);
    compared++;
    if ({det_q, rej_q} !== 2'b01) begin mismatched++; $display("FAIL case5_flush_reject: det/rej %b want 01", {det_q, rej_q}); end
    send(0, 0);
  endtask

  task automatic test_gaps_and_stop0();
    logic early;
    cfg_case1();
    send(150, 5);
    // Live config changes after arming must not affect this event.
    set_win(0, 2, 4, 1000, 2000);
    stop_max = 10'd2;
    early = 1'b0;
    send(0, 5);   early |= det_q | rej_q;
    send(300, 5); early |= det_q | rej_q;
    send(0, 5);   early |= det_q | rej_q;
    send(0, 5);   early |= det_q | rej_q;
    send(0, 5);   early |= det_q | rej_q;
    compared++;
    if (early !== 1'b0) begin mismatched++; $display("FAIL case6_early_pulse: got %b want 0", early); end
    send(0, 5);
    compared++;
    if ({det_q, rej_q} !== 2'b10) begin mismatched++; $display("FAIL case6_gap_decision: det/rej %b want 10", {det_q, rej_q}); end
    compared++;
    if (hit_mask !== 4'b0001) begin mismatched++; $display("FAIL case6_gap_hit_mask: got %b want 0001", hit_mask); end
    send(0, 5);
    cfg_case1();
    set_win(0, 0, 0, 100, 200);
    stop_max = 10'd0;
    send(150, 0);
    compared++;
    if ({det_q, rej_q, fsm_state, hit_mask} !== 8'b10100001) begin
      mismatched++; $display("FAIL case6_stop0: got %b want 10100001", {det_q, rej_q, fsm_state, hit_mask});
    end
    send(0, 0);
  endtask

  initial begin
    test_reset();
    test_window_detect();
    test_window_reject();
    test_threshold_refract();
    test_partial_hits();
    test_reset_abort();
    test_gaps_and_stop0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
